// File: rtl/uart_reg_master_pkg.sv
// uart_reg_master_pkg: command bytes, bus widths and FSM encoding shared by the UART register master.
package uart_reg_master_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;
    typedef enum logic [3:0] {
        IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L, WRITE, RD_WAIT, TX_H, TX_L, TX_ACK, TX_NAK
    } state_t;
    function automatic logic is_busy(state_t s);
        return s inside {WRITE, RD_WAIT, TX_H, TX_L, TX_ACK, TX_NAK};
    endfunction
    function automatic logic in_frame(state_t s);
        return s inside {ADDR_H, ADDR_L, DATA_H, DATA_L};
    endfunction
endpackage

// File: rtl/uart_reg_master.sv
// uart_reg_master: parses 'W' AH AL DH DL / 'R' AH AL byte frames into 16-bit register accesses.
// Optional inter-byte timeout enabled by defining REG_MASTER_TIMEOUT_EN.
import uart_reg_master_pkg::*;

module uart_reg_master #(
    parameter int READ_LAT    = 2,
    parameter int TIMEOUT_CYC = 2_700_000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_wen,
    input  logic [DATA_W-1:0] i_q,
    output logic              o_rx_drop,
    output logic              o_timeout
);
    state_t            r_state, w_next;
    logic              r_is_rd;
    logic [ADDR_W-1:0] r_asm_addr, r_addr;
    logic [7:0]        r_data_h;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic [3:0]        r_lat_cnt;
    logic              w_timeout;

    if (READ_LAT < 1 || READ_LAT > 15 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("uart_reg_master: READ_LAT must be 1..15 and TIMEOUT_CYC at least 2");
    end

`ifdef REG_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] r_tmo_cnt;
    // A byte landing on the expiry cycle wins over the timeout.
    assign w_timeout = in_frame(r_state) && !i_rx_valid && r_tmo_cnt == TW'(TIMEOUT_CYC - 1);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_tmo_cnt <= '0;
        else          r_tmo_cnt <= (in_frame(r_state) && !i_rx_valid && !w_timeout) ? r_tmo_cnt + 1'b1 : '0;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_rx_valid) w_next = (i_rx_data == CMD_WR || i_rx_data == CMD_RD) ? ADDR_H : TX_NAK;
            ADDR_H:  if (i_rx_valid) w_next = ADDR_L;
            ADDR_L:  if (i_rx_valid) w_next = r_is_rd ? RD_WAIT : DATA_H;
            DATA_H:  if (i_rx_valid) w_next = DATA_L;
            DATA_L:  if (i_rx_valid) w_next = WRITE;
            WRITE:   w_next = TX_ACK;
            RD_WAIT: if (r_lat_cnt == 4'(READ_LAT)) w_next = TX_H;
            TX_H:    if (i_tx_ready) w_next = TX_L;
            TX_L, TX_ACK, TX_NAK: if (i_tx_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_timeout) w_next = IDLE;
    end

    // RD_WAIT spans READ_LAT+1 cycles so i_q is sampled READ_LAT cycles after o_addr settles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_is_rd    <= 1'b0;
            r_asm_addr <= '0;
            r_addr     <= '0;
            r_data_h   <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_lat_cnt  <= '0;
        end else begin
            if (r_state == IDLE && i_rx_valid) r_is_rd <= i_rx_data == CMD_RD;
            if (r_state == ADDR_H && i_rx_valid) r_asm_addr[15:8] <= i_rx_data;
            if (r_state == ADDR_L && i_rx_valid) begin
                r_asm_addr[7:0] <= i_rx_data;
                if (r_is_rd) r_addr <= {r_asm_addr[15:8], i_rx_data};
            end
            if (r_state == DATA_H && i_rx_valid) r_data_h <= i_rx_data;
            if (r_state == DATA_L && i_rx_valid) begin
                r_addr  <= r_asm_addr;
                r_wdata <= {r_data_h, i_rx_data};
            end
            r_lat_cnt <= (r_state == RD_WAIT) ? r_lat_cnt + 4'd1 : '0;
            if (r_state == RD_WAIT && r_lat_cnt == 4'(READ_LAT)) r_rdata <= i_q;
        end
    end

    always_comb begin
        o_wen      = r_state == WRITE;
        o_tx_valid = r_state inside {TX_H, TX_L, TX_ACK, TX_NAK};
        o_tx_data  = r_state == TX_H   ? r_rdata[15:8] :
                     r_state == TX_L   ? r_rdata[7:0]  :
                     r_state == TX_ACK ? ACK :
                     r_state == TX_NAK ? NAK : 8'h00;
        o_rx_drop  = i_rx_valid && is_busy(r_state);
        o_timeout  = w_timeout;
        o_addr     = r_addr;
        o_wdata    = r_wdata;
    end
endmodule

// File: tb/tb_uart_reg_master.sv
// tb_uart_reg_master: scoreboard bench; expected TX bytes and writes are queued, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_uart_reg_master;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0, tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_valid, wen, rx_drop, timeout;
    logic [15:0] addr, wdata, q, q1;
    logic [15:0] regs [16];
    logic [7:0]  tx_q [$];
    logic [31:0] wr_q [$];
    logic [31:0] e_wr;
    int checks = 0, failures = 0, drop_cnt = 0, tmo_cnt = 0, wen_cnt = 0;

    always #5 clk = ~clk;

    uart_reg_master #(.READ_LAT(2), .TIMEOUT_CYC(100)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
        .o_addr(addr), .o_wdata(wdata), .o_wen(wen), .i_q(q),
        .o_rx_drop(rx_drop), .o_timeout(timeout)
    );

    // Register map responder: 16 registers at 0x0000-0x000F, two-cycle read pipeline.
    initial for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
    initial begin q = 16'h0000; q1 = 16'h0000; end
    always @(posedge clk) begin
        q1 <= (addr < 16'd16) ? regs[addr[3:0]] : 16'h0000;
        q  <= q1;
        if (wen && addr < 16'd16) regs[addr[3:0]] <= wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_tx: got %0h expected none", tx_data);
                end else chk("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
            end
            if (wen) begin
                wen_cnt++;
                if (wr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_wen: got addr %0h data %0h expected none", addr, wdata);
                end else begin
                    e_wr = wr_q.pop_front();
                    chk("wr_addr", {16'h0, addr}, {16'h0, e_wr[31:16]});
                    chk("wr_data", {16'h0, wdata}, {16'h0, e_wr[15:0]});
                end
            end
            if (rx_drop) drop_cnt++;
            if (timeout) tmo_cnt++;
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (tx_q.size() != 0 || wr_q.size() != 0); i++) @(negedge clk);
        chk("drain_pending", tx_q.size() + wr_q.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_tx_valid"}, {31'h0, tx_valid}, 0);
        chk({tag, "_tx_data"}, {24'h0, tx_data}, 0);
        chk({tag, "_wen"}, {31'h0, wen}, 0);
        chk({tag, "_addr"}, {16'h0, addr}, 0);
        chk({tag, "_wdata"}, {16'h0, wdata}, 0);
        chk({tag, "_rx_drop"}, {31'h0, rx_drop}, 0);
        chk({tag, "_timeout"}, {31'h0, timeout}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0, d0, t0;
        logic got, stable;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        wr_q.push_back({16'h0004, 16'h1234}); tx_q.push_back(8'h06);
        send(8'h57); send(8'h00); send(8'h04); send(8'h12); send(8'h34);
        drain();

        w0 = wen_cnt;
        tx_q.push_back(8'h12); tx_q.push_back(8'h34);
        send(8'h52); send(8'h00); send(8'h04);
        drain();
        chk("read_no_wen", wen_cnt, w0);

        tx_q.push_back(8'h00); tx_q.push_back(8'h00);
        send(8'h52); send(8'h00); send(8'h20);
        drain();

        tx_q.push_back(8'h15);
        send(8'h41);
        drain();
        wr_q.push_back({16'h0000, 16'hABCD}); tx_q.push_back(8'h06);
        send(8'h57); send(8'h00); send(8'h00); send(8'hAB); send(8'hCD);
        drain();
        tx_q.push_back(8'hAB); tx_q.push_back(8'hCD);
        send(8'h52); send(8'h00); send(8'h00);
        drain();

        tx_ready = 1'b0;
        d0 = drop_cnt;
        tx_q.push_back(8'h12); tx_q.push_back(8'h34);
        send(8'h52); send(8'h00); send(8'h04);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = tx_valid;
        end
        chk("bp_valid_rise", {31'h0, got}, 1);
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            rx_data = 8'h57; rx_valid = (i == 10);
            @(negedge clk);
            if (!tx_valid || tx_data !== 8'h12) stable = 1'b0;
        end
        rx_valid = 1'b0;
        chk("bp_stable", {31'h0, stable}, 1);
        chk("bp_drop_count", drop_cnt - d0, 1);
        tx_ready = 1'b1;
        drain();
        tx_q.push_back(8'hAB); tx_q.push_back(8'hCD);
        send(8'h52); send(8'h00); send(8'h00);
        drain();

`ifdef REG_MASTER_TIMEOUT_EN
        t0 = tmo_cnt; w0 = wen_cnt;
        send(8'h57); send(8'h00);
        repeat (110) @(posedge clk);
        chk("timeout_pulses", tmo_cnt - t0, 1);
        chk("timeout_no_wen", wen_cnt, w0);
        tx_q.push_back(8'hAB); tx_q.push_back(8'hCD);
        send(8'h52); send(8'h00); send(8'h00);
        drain();
`else
        t0 = tmo_cnt;
        chk("no_timeout", tmo_cnt, t0);
`endif

        send(8'h57); send(8'h00); send(8'h04);
        @(posedge clk); #3 rst_n = 1'b0;
        #1 chk_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wr_q.push_back({16'h0005, 16'h5566}); tx_q.push_back(8'h06);
        send(8'h57); send(8'h00); send(8'h05); send(8'h55); send(8'h66);
        drain();
        tx_q.push_back(8'h55); tx_q.push_back(8'h66);
        send(8'h52); send(8'h00); send(8'h05);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
